// File: rtl/aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_pipe
//
// Pipelined, multi-lane AES ShiftRows / InvShiftRows with valid/ready flow
// control and a sideband tag carried alongside each beat.
//
// The byte permutation is applied combinationally to in_state and the result
// is captured into stage 0. Stages 1..STAGES-1 are plain elastic registers.
// The output is driven from the last stage. Each stage reloads whenever it is
// empty or its contents move on, so bubbles collapse under backpressure and
// the pipe sustains one beat per cycle while out_ready stays high.
//
// Build option:
//   AES_SR_INV_EN  when defined, in_inv selects InvShiftRows per beat;
//                  when undefined, only the forward transform is built,
//                  in_inv is ignored and out_inv is always 0.
//
// Parameters:
//   LANES   independent 128-bit states per beat
//   STAGES  register stages (>=1), latency when not stalled
//   TAG_W   sideband tag width
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_inv                direction for the whole beat (1 = inverse)
//   in_tag, in_state      beat payload, lane L at [128L+127:128L]
//   out_valid / out_ready downstream handshake
//   out_inv, out_tag      direction and tag of the outgoing beat
//   out_state             transformed states, same lane packing
//   busy                  any stage holds a beat
// ---------------------------------------------------------------------------
module aes_shift_rows_pipe #(
   parameter int LANES  = 1,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_inv,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic [128*LANES-1:0] in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_inv,
   output logic [TAG_W-1:0]     out_tag,
   output logic [128*LANES-1:0] out_state,
   output logic                 busy
);

   localparam int SW = 128 * LANES;

   // ------------------------------------------------------------------
   // Byte permutation. Byte i of a lane sits at bits [8i+7:8i], with
   // i = r + 4c. Row r is rotated left by r columns (right for inverse).
   // ------------------------------------------------------------------
   logic [SW-1:0] xf_state;
   logic          xf_inv;

   generate
      for (genvar gi = 0; gi < LANES * 16; gi++) begin : g_byte
         localparam int L   = gi / 16;
         localparam int B   = gi % 16;
         localparam int R   = B % 4;
         localparam int C   = B / 4;
         localparam int FWD = 128 * L + 8 * (R + 4 * ((C + R) % 4));
`ifdef AES_SR_INV_EN
         localparam int INV = 128 * L + 8 * (R + 4 * ((C - R + 4) % 4));
         assign xf_state[gi*8 +: 8] = in_inv ? in_state[INV +: 8] : in_state[FWD +: 8];
`else
         assign xf_state[gi*8 +: 8] = in_state[FWD +: 8];
`endif
      end
   endgenerate

`ifdef AES_SR_INV_EN
   assign xf_inv = in_inv;
`else
   // Forward-only build: the direction input has no effect.
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
   assign xf_inv        = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Elastic stage registers
   // ------------------------------------------------------------------
   logic [STAGES-1:0]            v_q, v_d;
   logic [STAGES-1:0]            inv_q, inv_d;
   logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [STAGES-1:0][SW-1:0]    data_q, data_d;

   // What each stage would load: stage 0 takes the transformed input,
   // every later stage takes its predecessor.
   logic [STAGES-1:0]            src_v, src_inv;
   logic [STAGES-1:0][TAG_W-1:0] src_tag;
   logic [STAGES-1:0][SW-1:0]    src_data;

   assign src_v[0]    = in_valid;
   assign src_inv[0]  = xf_inv;
   assign src_tag[0]  = in_tag;
   assign src_data[0] = xf_state;

   generate
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_src
         assign src_v[gi]    = v_q[gi-1];
         assign src_inv[gi]  = inv_q[gi-1];
         assign src_tag[gi]  = tag_q[gi-1];
         assign src_data[gi] = data_q[gi-1];
      end
   endgenerate

   // load[k]: stage k may take a new value this cycle. The chain runs from
   // out_ready backwards, so a stalled full pipe blocks in_ready while any
   // empty stage still accepts (bubble collapse).
   logic [STAGES:0] load;

   always_comb begin
      load         = '0;
      load[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = !v_q[k] || load[k+1];
      end
   end

   always_comb begin
      v_d    = v_q;
      inv_d  = inv_q;
      tag_d  = tag_q;
      data_d = data_q;
      for (int k = 0; k < STAGES; k++) begin
         if (load[k]) begin
            v_d[k] = src_v[k];
            // Payload only moves with a real beat; empty slots keep old data.
            if (src_v[k]) begin
               inv_d[k]  = src_inv[k];
               tag_d[k]  = src_tag[k];
               data_d[k] = src_data[k];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= '0;
         inv_q  <= '0;
         tag_q  <= '0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         inv_q  <= inv_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign in_ready  = load[0];
   assign out_valid = v_q[STAGES-1];
   assign out_inv   = inv_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign out_state = data_q[STAGES-1];
   assign busy      = |v_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_shift_rows_pipe
//
// Drives aes_shift_rows_pipe (two lanes, three stages) with directed vectors
// and random traffic. A scoreboard queue holds the expected result of every
// accepted beat, computed from the row-rotation rule on a 4x4 byte matrix.
// Outputs are sampled on the falling edge; inputs change 2 time units after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_aes_shift_rows_pipe;

   localparam int LANES  = 2;
   localparam int STAGES = 3;
   localparam int TAG_W  = 4;
   localparam int SW     = 128 * LANES;

   localparam logic [127:0] V1     = 128'h89c2abb23688ac1c675eb2d4cf2a263e;
   localparam logic [127:0] V1_FWD = 128'h365e26b2672aab1ccfc2acd48988b23e;
   localparam logic [127:0] L1_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] L1_FWD = 128'h0b06010c07020d08030e09040f0a0500;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid, in_ready, in_inv;
   logic [TAG_W-1:0] in_tag;
   logic [SW-1:0]    in_state;
   logic             out_valid, out_ready, out_inv;
   logic [TAG_W-1:0] out_tag;
   logic [SW-1:0]    out_state;
   logic             busy;

   always #5 clk = ~clk;

   aes_shift_rows_pipe #(
      .LANES  (LANES),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_tag    (in_tag),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inv   (out_inv),
      .out_tag   (out_tag),
      .out_state (out_state),
      .busy      (busy)
   );

   typedef struct packed {
      logic             inv;
      logic [TAG_W-1:0] tag;
      logic [SW-1:0]    st;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    n_out = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: view a lane as a 4x4 byte matrix m[row][col]; row r is
   // rotated left by r positions (right by r for the inverse).
   function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
      logic [7:0]   m [4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = s[8*(r+4*c) +: 8];
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r+4*c) +: 8] = inv ? m[r][(c+4-r)%4] : m[r][(c+r)%4];
      return o;
   endfunction

   function automatic logic eff_inv(input logic inv);
`ifdef AES_SR_INV_EN
      return inv;
`else
      return inv & 1'b0;   // forward-only build ignores the direction
`endif
   endfunction

   function automatic beat_t model(input logic inv, input logic [TAG_W-1:0] tag,
                                   input logic [SW-1:0] st);
      beat_t b;
      b.inv = eff_inv(inv);
      b.tag = tag;
      b.st  = '0;
      for (int l = 0; l < LANES; l++)
         b.st[128*l +: 128] = ref_sr(st[128*l +: 128], b.inv);
      return b;
   endfunction

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] s;
      for (int w = 0; w < SW / 32; w++) s[32*w +: 32] = $urandom;
      return s;
   endfunction

   // Monitor / scoreboard on the falling edge.
   beat_t e;
   beat_t prev;
   logic  hold_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_state", out_state, prev.st);
            check("hold_tag",   out_tag,   prev.tag);
            check("hold_inv",   out_inv,   prev.inv);
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_state", out_state, e.st);
               check("out_tag",   out_tag,   e.tag);
               check("out_inv",   out_inv,   e.inv);
               n_out++;
               $display("beat %0d tag=%0d inv=%0d state=%h", n_out, out_tag, out_inv, out_state);
            end
         end
         hold_prev = out_valid && !out_ready;
         prev      = '{inv: out_inv, tag: out_tag, st: out_state};
         if (in_valid && in_ready)
            exp_q.push_back(model(in_inv, in_tag, in_state));
      end
   end

   // Present a beat and hold it until accepted; returns 2 units after the
   // accepting edge with in_valid low.
   task automatic send(input logic inv, input logic [TAG_W-1:0] tag, input logic [SW-1:0] st);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_inv   = inv;
      in_tag   = tag;
      in_state = st;
      for (int t = 0; t < 50 && !done; t++) begin
         #1;
         done = in_ready;
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      check("send_accept", done, 1);
   endtask

   // Count edges from the transfer cycle until out_valid shows up.
   task automatic wait_out(output int n);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_in_ready"},  in_ready,  1);
      check({tag, "_out_state"}, out_state, 0);
      check({tag, "_out_tag"},   out_tag,   0);
      check({tag, "_out_inv"},   out_inv,   0);
   endtask

   int lat;
   int t0;
   int n0;
   int acc;
   bit took;

   initial begin
      in_valid  = 1'b0;
      in_inv    = 1'b0;
      in_tag    = '0;
      in_state  = '0;
      out_ready = 1'b1;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("rst0");
      rst = 1'b0;
      @(posedge clk);
      #2;

      // Forward vector on lane 0, byte-index ramp on lane 1.
      send(1'b0, 4'd1, {L1_IN, V1});
      wait_out(lat);
      check("fwd_latency", lat, STAGES);
      check("fwd_lane0",   out_state[127:0],   V1_FWD);
      check("fwd_lane1",   out_state[255:128], L1_FWD);
      check("fwd_tag",     out_tag, 4'd1);
      check("fwd_inv",     out_inv, 0);
      @(posedge clk);
      #2;

      // Inverse vector (forward result when the inverse is not built).
      send(1'b1, 4'd2, {L1_FWD, V1_FWD});
      wait_out(lat);
      check("inv_latency", lat, STAGES);
`ifdef AES_SR_INV_EN
      check("inv_lane0", out_state[127:0],   V1);
      check("inv_lane1", out_state[255:128], L1_IN);
      check("inv_inv",   out_inv, 1);
`else
      check("inv_lane0", out_state[127:0], ref_sr(V1_FWD, 1'b0));
      check("inv_inv",   out_inv, 0);
`endif
      check("inv_tag", out_tag, 4'd2);
      @(posedge clk);
      #2;

      // Back-to-back streaming, alternating direction.
      t0 = cyc;
      n0 = n_out;
      for (int i = 0; i < 16; i++)
         send(1'(i % 2), 4'(i), rand_state());
      check("stream_cycles", cyc - t0, 16);
      repeat (STAGES) @(posedge clk);
      #2;
      check("stream_outputs", n_out - n0, 16);
      check("stream_drained", exp_q.size(), 0);

      // Backpressure: downstream stalled for five cycles.
      out_ready = 1'b0;
      acc       = 0;
      in_valid  = 1'b1;
      in_inv    = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom_range(0, 15));
      in_state  = rand_state();
      for (int t = 0; t < 5; t++) begin
         #1;
         took = in_ready;
         @(posedge clk);
         #2;
         if (took) begin
            acc++;
            in_inv   = 1'($urandom_range(0, 1));
            in_tag   = 4'($urandom_range(0, 15));
            in_state = rand_state();
         end
      end
      check("bp_accepted", acc, STAGES);
      check("bp_in_ready", in_ready, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      out_ready = 1'b1;
      repeat (STAGES + 2) @(posedge clk);
      #2;
      check("bp_drained", exp_q.size(), 0);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(1'b0, 4'd7, rand_state());
      send(1'b1, 4'd8, rand_state());
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_outputs("rst_mid");
      @(posedge clk);
      #2;
      rst       = 1'b0;
      out_ready = 1'b1;
      send(1'b0, 4'd5, {L1_IN, V1});
      wait_out(lat);
      check("post_rst_latency", lat, STAGES);
      check("post_rst_lane0",   out_state[127:0], V1_FWD);
      check("post_rst_tag",     out_tag, 4'd5);
      @(posedge clk);
      #2;

      // Random traffic: valid and ready toggle independently.
      for (int t = 0; t < 400; t++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_inv    = 1'($urandom_range(0, 1));
         in_tag    = 4'($urandom_range(0, 15));
         in_state  = rand_state();
         @(posedge clk);
         #2;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 2) @(posedge clk);
      #2;
      check("rand_drained", exp_q.size(), 0);
      check("rand_busy",    busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
